exu_stage: RTL and testbench

//  Multicycle execute stage of the RV32I core, between IDU (upstream) and LSU/WBU (downstream).

---
 rtl/exu_stage_pkg.sv | 80 ++++++++
 rtl/exu_stage_alu.sv | 32 +++
 rtl/exu_stage.sv | 177 +++++++++++++++++
 tb/tb_exu_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exu_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch types, operand selects, FSM states.
package exu_stage_pkg;

    localparam int XLEN_C = 32;

    typedef enum logic [3:0] {
        ALUOP_ADD            = 4'd0,
        ALUOP_SUB            = 4'd1,
        ALUOP_LEFT           = 4'd2,
        ALUOP_RIGHT_L        = 4'd3,
        ALUOP_RIGHT_A        = 4'd4,
        ALUOP_AND            = 4'd5,
        ALUOP_OR             = 4'd6,
        ALUOP_XOR            = 4'd7,
        ALUOP_EQ             = 4'd8,
        ALUOP_LOWER_SIGNED   = 4'd9,
        ALUOP_LOWER_UNSIGNED = 4'd10
    } aluop_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } src2_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_TGT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_branch(input logic [3:0] br);
        case (br)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [3:0] br);
        case (br)
            BR_JAL, BR_JALR: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // Branches whose condition is the complement of the ALU compare result
    function automatic logic br_invert(input logic [3:0] br);
        case (br)
            BR_BNE, BR_BGE, BR_BGEU: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        case (op)
            ALUOP_LEFT, ALUOP_RIGHT_L, ALUOP_RIGHT_A: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_stage_alu.sv
// Combinational RV32I ALU shared by the result and target passes of the execute stage.
module exu_stage_alu
    import exu_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);

    // Operation select; compares return 0/1 in bit 0
    always_comb begin
        res = {W{1'b0}};
        case (op)
            ALUOP_ADD:            res = a + b;
            ALUOP_SUB:            res = a - b;
            ALUOP_LEFT:           res = a << b[4:0];
            ALUOP_RIGHT_L:        res = a >> b[4:0];
            ALUOP_RIGHT_A:        res = $signed(a) >>> b[4:0];
            ALUOP_AND:            res = a & b;
            ALUOP_OR:             res = a | b;
            ALUOP_XOR:            res = a ^ b;
            ALUOP_EQ:             res = {{(W-1){1'b0}}, (a == b)};
            ALUOP_LOWER_SIGNED:   res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOP_LOWER_UNSIGNED: res = {{(W-1){1'b0}}, (a < b)};
            default:              res = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/exu_stage.sv
// Multicycle RV32I execute stage: one ALU shared between the result pass and the branch/jump target pass.
module exu_stage
    import exu_stage_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int RESET_PC_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [3:0]      in_aluop,
    input  logic [1:0]      in_src1_sel,
    input  logic [1:0]      in_src2_sel,
    input  logic [3:0]      in_br_type,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [3:0]      in_mem_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [3:0]      out_mem_op,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    if (RESET_PC_HOLD != 0) begin : g_reset_pc_hold_unsupported
    end

    state_e          state_r, next_state_s;
    logic [XLEN-1:0] pc_r, rs1_r, rs2_r, imm_r, res_r, tgt_r;
    logic [3:0]      aluop_r, br_r, mem_op_r;
    logic [1:0]      src1_sel_r, src2_sel_r;
    logic [4:0]      rd_r;
    logic            wen_r, tgt_seen_r;
    logic [3:0]      alu_op_s;
    logic [XLEN-1:0] alu_a_s, alu_b_s, src2_raw_s, alu_res_s;
    logic            taken_s, accept_s;

    logic            in_ready_r, out_valid_r, out_wen_r, redirect_valid_r;
    logic [XLEN-1:0] out_res_r, out_store_data_r, redirect_pc_r;
    logic [4:0]      out_rd_r;
    logic [3:0]      out_mem_op_r;

    assign accept_s = (state_r == ST_IDLE) && in_valid && in_ready_r;
    assign taken_s  = alu_res_s[0] ^ br_invert(br_r);

    // Operand and op muxes; the target pass forces ADD of base+imm
    always_comb begin
        alu_op_s   = aluop_r;
        alu_a_s    = {XLEN{1'b0}};
        alu_b_s    = {XLEN{1'b0}};
        src2_raw_s = {XLEN{1'b0}};
        if (state_r == ST_TGT) begin
            alu_op_s = ALUOP_ADD;
            alu_a_s  = (br_r == BR_JALR) ? rs1_r : pc_r;
            alu_b_s  = imm_r;
        end else begin
            case (src1_sel_r)
                SRC1_RS1: alu_a_s = rs1_r;
                SRC1_PC:  alu_a_s = pc_r;
                default:  alu_a_s = {XLEN{1'b0}};
            endcase
            case (src2_sel_r)
                SRC2_RS2:  src2_raw_s = rs2_r;
                SRC2_IMM:  src2_raw_s = imm_r;
                SRC2_FOUR: src2_raw_s = 32'd4;
                default:   src2_raw_s = {XLEN{1'b0}};
            endcase
            if (is_shift(aluop_r)) begin
                alu_b_s = {27'd0, src2_raw_s[4:0]};
            end else begin
                alu_b_s = src2_raw_s;
            end
        end
    end

    exu_stage_alu #(.W(XLEN)) u_alu (
        .op  (alu_op_s),
        .a   (alu_a_s),
        .b   (alu_b_s),
        .res (alu_res_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_EXEC;
                else          next_state_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (is_jump(br_r) || (is_branch(br_r) && taken_s)) next_state_s = ST_TGT;
                else                                               next_state_s = ST_DONE;
            end
            ST_TGT:  next_state_s = ST_DONE;
            ST_DONE: begin
                if (out_valid_r && out_ready) next_state_s = ST_IDLE;
                else                          next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Instruction latch and the two ALU pass results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= '0; rs1_r <= '0; rs2_r <= '0; imm_r <= '0;
            aluop_r <= 4'd0; br_r <= 4'd0; mem_op_r <= 4'd0;
            src1_sel_r <= 2'd0; src2_sel_r <= 2'd0;
            rd_r <= 5'd0; wen_r <= 1'b0;
            res_r <= '0; tgt_r <= '0; tgt_seen_r <= 1'b0;
        end else begin
            if (accept_s) begin
                pc_r <= in_pc; rs1_r <= in_rs1_val; rs2_r <= in_rs2_val; imm_r <= in_imm;
                aluop_r <= in_aluop; br_r <= in_br_type; mem_op_r <= in_mem_op;
                src1_sel_r <= in_src1_sel; src2_sel_r <= in_src2_sel;
                rd_r <= in_rd; wen_r <= in_wen;
                tgt_seen_r <= 1'b0;
            end
            if (state_r == ST_EXEC) res_r <= alu_res_s;
            if (state_r == ST_TGT) begin
                tgt_r      <= (br_r == BR_JALR) ? {alu_res_s[XLEN-1:1], 1'b0} : alu_res_s;
                tgt_seen_r <= 1'b1;
            end
        end
    end

    // Registered outputs: loaded on entry to DONE, redirect pulses once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0; out_valid_r <= 1'b0; out_wen_r <= 1'b0;
            redirect_valid_r <= 1'b0; out_res_r <= '0; out_store_data_r <= '0;
            redirect_pc_r <= '0; out_rd_r <= 5'd0; out_mem_op_r <= 4'd0;
        end else begin
            in_ready_r       <= (next_state_s == ST_IDLE);
            redirect_valid_r <= 1'b0;
            if ((state_r == ST_DONE) && !out_valid_r) begin
                out_valid_r      <= 1'b1;
                out_res_r        <= res_r;
                out_store_data_r <= rs2_r;
                out_rd_r         <= rd_r;
                out_wen_r        <= wen_r & ~is_branch(br_r);
                out_mem_op_r     <= mem_op_r;
                redirect_valid_r <= tgt_seen_r;
                redirect_pc_r    <= tgt_r;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_res        = out_res_r;
    assign out_store_data = out_store_data_r;
    assign out_rd         = out_rd_r;
    assign out_wen        = out_wen_r;
    assign out_mem_op     = out_mem_op_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_exu_stage.sv
// Directed self-checking bench for exu_stage: latency, results, redirects, stall and async reset.
module tb_exu_stage;
    import exu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [3:0]  in_aluop, in_br_type, in_mem_op;
    logic [1:0]  in_src1_sel, in_src2_sel;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_res, out_store_data, redirect_pc;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [3:0]  out_mem_op;
    logic        redirect_valid;

    int n_checks = 0;
    int n_errors = 0;
    int redir_cnt = 0;

    always #5 clk = ~clk;

    exu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_aluop(in_aluop), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_br_type(in_br_type), .in_rd(in_rd), .in_wen(in_wen), .in_mem_op(in_mem_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_wen(out_wen),
        .out_mem_op(out_mem_op), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always @(posedge clk) begin
        if (redirect_valid) redir_cnt <= redir_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic scramble_inputs();
        in_pc = 32'hDEADBEEF; in_rs1_val = 32'hDEADBEEF; in_rs2_val = 32'hDEADBEEF;
        in_imm = 32'hDEADBEEF; in_aluop = 4'hF; in_src1_sel = 2'd3; in_src2_sel = 2'd3;
        in_br_type = 4'hF; in_rd = 5'd31; in_wen = 1'b1; in_mem_op = 4'hF;
    endtask

    // Returns 1ns after the accept edge
    task automatic issue(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [3:0] op, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [3:0] br, input logic [4:0] rd,
                         input logic wen, input logic [3:0] mop);
        @(negedge clk);
        in_pc = pc; in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm;
        in_aluop = op; in_src1_sel = s1; in_src2_sel = s2; in_br_type = br;
        in_rd = rd; in_wen = wen; in_mem_op = mop; in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL issue_timeout: in_ready observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Called at a negedge while out_valid=1: completes the out handshake
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble_inputs();
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5+7, store-data/mem_op passthrough, 2-cycle latency
        base = redir_cnt;
        issue(32'h100, 32'd5, 32'd7, 32'd0, ALUOP_ADD, SRC1_RS1, SRC2_RS2, BR_NONE, 5'd3, 1'b1, 4'h9);
        @(negedge clk); check("add_valid_t0", {31'd0, out_valid}, 32'd0);
        check("add_in_ready_busy", {31'd0, in_ready}, 32'd0);
        @(negedge clk); check("add_valid_t1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("add_valid_t2", {31'd0, out_valid}, 32'd1);
        check("add_res", out_res, 32'd12);
        check("add_store", out_store_data, 32'd7);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_wen", {31'd0, out_wen}, 32'd1);
        check("add_mem_op", {28'd0, out_mem_op}, 32'h9);
        check("add_no_redirect", {31'd0, redirect_valid}, 32'd0);
        drain("add");
        check("add_redir_cnt", redir_cnt - base, 32'd0);

        // BNE equal operands: not taken, wen forced low
        base = redir_cnt;
        issue(32'h200, 32'd3, 32'd3, 32'd64, ALUOP_EQ, SRC1_RS1, SRC2_RS2, BR_BNE, 5'd5, 1'b1, 4'h0);
        negs(2); check("bne_valid_t1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("bne_valid_t2", {31'd0, out_valid}, 32'd1);
        check("bne_wen", {31'd0, out_wen}, 32'd0);
        check("bne_res", out_res, 32'd1);
        drain("bne");
        check("bne_redir_cnt", redir_cnt - base, 32'd0);

        // BLT taken: 3-cycle latency, single redirect pulse
        base = redir_cnt;
        issue(32'h80000010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, ALUOP_LOWER_SIGNED,
              SRC1_RS1, SRC2_RS2, BR_BLT, 5'd0, 1'b1, 4'h0);
        negs(3); check("blt_valid_t2", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("blt_valid_t3", {31'd0, out_valid}, 32'd1);
        check("blt_redirect", {31'd0, redirect_valid}, 32'd1);
        check("blt_redirect_pc", redirect_pc, 32'h80000000);
        check("blt_wen", {31'd0, out_wen}, 32'd0);
        @(negedge clk); check("blt_redirect_drop", {31'd0, redirect_valid}, 32'd0);
        check("blt_valid_hold", {31'd0, out_valid}, 32'd1);
        drain("blt");
        check("blt_redir_cnt", redir_cnt - base, 32'd1);

        // JALR: link pc+4, target rs1+imm with bit 0 cleared
        issue(32'h80000100, 32'h80001003, 32'd0, 32'd0, ALUOP_ADD, SRC1_PC, SRC2_FOUR,
              BR_JALR, 5'd1, 1'b1, 4'h0);
        negs(4); check("jalr_valid", {31'd0, out_valid}, 32'd1);
        check("jalr_res", out_res, 32'h80000104);
        check("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        check("jalr_redirect_pc", redirect_pc, 32'h80001002);
        check("jalr_wen", {31'd0, out_wen}, 32'd1);
        drain("jalr");

        // JAL with wraparound of both link and target
        issue(32'hFFFFFFFC, 32'd0, 32'd0, 32'd8, ALUOP_ADD, SRC1_PC, SRC2_FOUR,
              BR_JAL, 5'd1, 1'b1, 4'h0);
        negs(4); check("jal_res_wrap", out_res, 32'h00000000);
        check("jal_redirect_pc_wrap", redirect_pc, 32'h00000004);
        drain("jal");

        // BGE with rs1 < rs2: not taken
        base = redir_cnt;
        issue(32'h300, 32'hFFFFFFFF, 32'd1, 32'd16, ALUOP_LOWER_SIGNED, SRC1_RS1, SRC2_RS2,
              BR_BGE, 5'd0, 1'b0, 4'h0);
        negs(3); check("bge_valid_t2", {31'd0, out_valid}, 32'd1);
        drain("bge");
        check("bge_redir_cnt", redir_cnt - base, 32'd0);

        // SRA with shift amount masked to 4
        issue(32'h0, 32'h80000000, 32'h00000024, 32'd0, ALUOP_RIGHT_A, SRC1_RS1, SRC2_RS2,
              BR_NONE, 5'd7, 1'b1, 4'h0);
        negs(3); check("sra_res", out_res, 32'hF8000000);
        drain("sra");

        // SLL with masked shift, then stall 5 cycles
        base = redir_cnt;
        issue(32'h0, 32'd1, 32'h00000021, 32'd0, ALUOP_LEFT, SRC1_RS1, SRC2_RS2,
              BR_NONE, 5'd8, 1'b1, 4'h0);
        negs(3); check("sll_res", out_res, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_res", out_res, 32'd2);
            check("stall_rd", {27'd0, out_rd}, 32'd8);
            check("stall_redirect", {31'd0, redirect_valid}, 32'd0);
        end
        drain("sll");
        check("sll_redir_cnt", redir_cnt - base, 32'd0);

        // Async reset while in TGT drops the instruction
        base = redir_cnt;
        issue(32'h80000010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, ALUOP_LOWER_SIGNED,
              SRC1_RS1, SRC2_RS2, BR_BLT, 5'd0, 1'b0, 4'h0);
        negs(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("arst_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready_after", {31'd0, in_ready}, 32'd1);
        negs(3);
        check("arst_no_stale_valid", {31'd0, out_valid}, 32'd0);
        check("arst_redir_cnt", redir_cnt - base, 32'd0);

        issue(32'h400, 32'd100, 32'd0, 32'hFFFFFFFF, ALUOP_ADD, SRC1_RS1, SRC2_IMM,
              BR_NONE, 5'd9, 1'b1, 4'h0);
        negs(3); check("post_arst_valid", {31'd0, out_valid}, 32'd1);
        check("post_arst_res", out_res, 32'd99);
        drain("post_arst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
